n_way_sum_using_fifos: RTL and testbench

N_WAY_SUM_USING_FIFOS -- requirements
Module: n_way_sum_using_fifos

---
 rtl/n_way_sum_pkg.sv | 14 +
 rtl/flip_flop_fifo_with_counter.sv | 57 +++++
 rtl/n_way_sum_using_fifos.sv | 81 ++++++++
 tb/tb_n_way_sum_using_fifos.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/n_way_sum_pkg.sv
// Shared constants and width helpers for the n-way join/sum block.
package n_way_sum_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_N_INPUTS = 3;
  localparam int DEF_DEPTH    = 4;
  localparam int OUT_DEPTH    = 2;

  // Full-precision width of an unsigned sum of n operands of w bits each.
  function automatic int sum_width(input int w, input int n);
    return w + $clog2(n);
  endfunction

endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// Register-array FIFO with an occupancy counter; full/empty come straight from
// the registered count so they carry no combinational path from push/pop.
module flip_flop_fifo_with_counter
  import n_way_sum_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int depth = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] wr_data,
  input  logic             pop,
  output logic [width-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full    = (count == CNT_W'(depth));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/n_way_sum_using_fifos.sv
// Joins n_inputs independent valid/ready streams through per-stream FIFOs and
// emits the full-precision sum of one token from every stream per output beat.
module n_way_sum_using_fifos
  import n_way_sum_pkg::*;
#(
  parameter int width    = DEF_WIDTH,
  parameter int n_inputs = DEF_N_INPUTS,
  parameter int depth    = DEF_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [n_inputs-1:0]                 in_valid,
  output logic [n_inputs-1:0]                 in_ready,
  input  logic [n_inputs*width-1:0]           in_data,
  output logic                                sum_valid,
  input  logic                                sum_ready,
  output logic [width+$clog2(n_inputs)-1:0]   sum_data
);

  localparam int SUM_W = sum_width(width, n_inputs);

  logic [width-1:0]    head [n_inputs];
  logic [n_inputs-1:0] in_full;
  logic [n_inputs-1:0] in_empty;

  logic                vld_p0;
  logic [SUM_W-1:0]    sum_p0;
  logic                out_full;
  logic                out_empty;
  logic                out_pop;
  logic                out_can_accept;

  // Input stage: one FIFO per stream; ready depends only on registered occupancy.
  for (genvar g = 0; g < n_inputs; g++) begin : g_in_fifo
    flip_flop_fifo_with_counter #(
      .width (width),
      .depth (depth)
    ) u_in_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid[g] & ~in_full[g]),
      .wr_data (in_data[g*width +: width]),
      .pop     (vld_p0),
      .rd_data (head[g]),
      .full    (in_full[g]),
      .empty   (in_empty[g])
    );
  end

  assign in_ready = ~in_full;

  // Join stage: fire when every head is present and the output buffer has room.
  assign out_pop        = sum_valid & sum_ready;
  assign out_can_accept = ~out_full | out_pop;
  assign vld_p0         = ~(|in_empty) & out_can_accept;

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < n_inputs; i++) begin
      sum_p0 = sum_p0 + SUM_W'(head[i]);
    end
  end

  // Output stage: 2-entry buffer decouples the join from downstream stalls.
  flip_flop_fifo_with_counter #(
    .width (SUM_W),
    .depth (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (vld_p0),
    .wr_data (sum_p0),
    .pop     (out_pop),
    .rd_data (sum_data),
    .full    (out_full),
    .empty   (out_empty)
  );

  assign sum_valid = ~out_empty;

endmodule

// File: tb/tb_n_way_sum_using_fifos.sv
// Randomized and directed bench with a queue-based token scoreboard.
module tb_n_way_sum_using_fifos;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int D  = 4;
  localparam int SW = W + $clog2(N);

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic            sum_valid;
  logic            sum_ready;
  logic [SW-1:0]   sum_data;

  int checks = 0;
  int errors = 0;
  int n_sums = 0;
  int unsigned q [N][$];

  n_way_sum_using_fifos #(
    .width    (W),
    .n_inputs (N),
    .depth    (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_data(input int i, input int unsigned v);
    in_data[i*W +: W] = W'(v);
  endtask

  // Observe one clock: transfers are sampled at the falling edge, inputs are
  // changed by the caller just after the following rising edge.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) q[i].delete();
    end else begin
      if (sum_valid && sum_ready) begin
        bit ok = 1'b1;
        int unsigned exp = 0;
        for (int i = 0; i < N; i++) if (q[i].size() == 0) ok = 1'b0;
        if (!ok) begin
          check("sum_without_tokens", 32'(sum_valid), 32'd0);
        end else begin
          for (int i = 0; i < N; i++) exp += q[i].pop_front();
          check("sum_data", 32'(sum_data), exp);
        end
        n_sums++;
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && in_ready[i]) q[i].push_back(32'(in_data[i*W +: W]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int minq;
    in_valid  = '0;
    sum_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    minq = q[0].size();
    for (int i = 1; i < N; i++) if (q[i].size() < minq) minq = q[i].size();
    check("drain_complete_sets", 32'(minq), 32'd0);
    check("drain_valid", 32'(sum_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    int acc;
    int acc_n [N];
    int unsigned cur [N];
    logic [N-1:0] pre;
    logic [SW-1:0] held;
    bit hold_chk;

    rst = 1'b1; in_valid = '0; in_data = '0; sum_ready = 1'b1;
    tick(); tick();
    check("rst_sum_valid", 32'(sum_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd7);
    rst = 1'b0;

    // Single token latency.
    base = n_sums;
    in_valid = 3'b111; set_data(0, 1); set_data(1, 2); set_data(2, 3);
    tick();
    in_valid = '0;
    check("lat_c1_valid", 32'(sum_valid), 32'd0);
    tick();
    check("lat_c2_valid", 32'(sum_valid), 32'd1);
    check("lat_c2_data", 32'(sum_data), 32'd6);
    tick();
    check("single_after_valid", 32'(sum_valid), 32'd0);
    repeat (3) tick();
    check("single_count", 32'(n_sums - base), 32'd1);

    // Maximum operands must not wrap.
    in_valid = 3'b111; set_data(0, 255); set_data(1, 255); set_data(2, 255);
    tick();
    in_valid = '0;
    tick();
    check("max_valid", 32'(sum_valid), 32'd1);
    check("max_data", 32'(sum_data), 32'd765);
    repeat (2) tick();

    // One stream fills while the others are idle.
    acc = 0;
    in_valid = 3'b001;
    for (int k = 0; k < 5; k++) begin
      set_data(0, 10 + acc);
      pre = in_ready;
      tick();
      if (pre[0]) acc++;
    end
    check("s0_accepted", 32'(acc), 32'd4);
    check("s0_full_ready", 32'(in_ready), 32'b110);
    check("partial_no_sum", 32'(sum_valid), 32'd0);
    in_valid = 3'b110;
    base = n_sums;
    for (int k = 0; k < 4; k++) begin
      set_data(1, 20 + k); set_data(2, 30 + k);
      tick();
    end
    in_valid = '0;
    for (int k = 0; k < 20 && (n_sums - base) < 4; k++) tick();
    check("fill_sum_count", 32'(n_sums - base), 32'd4);
    tick();
    check("fill_ready_back", 32'(in_ready), 32'd7);

    // Back-pressure for 20 cycles, then sustained release.
    sum_ready = 1'b0;
    in_valid  = 3'b111;
    for (int i = 0; i < N; i++) begin cur[i] = $urandom_range(0, 255); acc_n[i] = 0; end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < N; i++) set_data(i, cur[i]);
      pre = in_ready;
      tick();
      for (int i = 0; i < N; i++) if (pre[i]) begin acc_n[i]++; cur[i] = $urandom_range(0, 255); end
    end
    check("bp_sum_valid", 32'(sum_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < N; i++) check("bp_accepted", 32'(acc_n[i]), 32'(D + 2));
    sum_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) set_data(i, cur[i]);
      check("tput_valid", 32'(sum_valid), 32'd1);
      pre = in_ready;
      tick();
      for (int i = 0; i < N; i++) if (pre[i]) cur[i] = $urandom_range(0, 255);
    end
    drain();

    // Reset with tokens in flight.
    sum_ready = 1'b0;
    in_valid  = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) set_data(i, $urandom_range(0, 255));
      tick();
    end
    in_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sum_valid", 32'(sum_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd7);
    sum_ready = 1'b1;
    base = n_sums;
    in_valid = 3'b111; set_data(0, 7); set_data(1, 8); set_data(2, 9);
    tick();
    in_valid = '0;
    tick();
    check("post_rst_valid", 32'(sum_valid), 32'd1);
    check("post_rst_data", 32'(sum_data), 32'd24);
    repeat (4) tick();
    check("post_rst_count", 32'(n_sums - base), 32'd1);

    // Random traffic with random downstream stalls.
    in_valid = '0;
    hold_chk = 1'b0;
    held = '0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(0, 3) != 0) begin
          in_valid[i] = 1'b1;
          set_data(i, ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255));
        end
      end
      sum_ready = ($urandom_range(0, 3) != 0);
      if (hold_chk) check("hold_data", 32'(sum_data), 32'(held));
      hold_chk = sum_valid && !sum_ready;
      held = sum_data;
      pre = in_ready;
      tick();
      for (int i = 0; i < N; i++) if (in_valid[i] && pre[i]) in_valid[i] = 1'b0;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
